// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: the ASCII command set and
// the decoder FSM state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CHAR_R_UC = 8'h52;
    localparam logic [7:0] CHAR_R_LC = 8'h72;
    localparam logic [7:0] CHAR_C_UC = 8'h43;
    localparam logic [7:0] CHAR_C_LC = 8'h63;
    localparam logic [7:0] CHAR_M_UC = 8'h4D;
    localparam logic [7:0] CHAR_M_LC = 8'h6D;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ECHO   = 2'd2
    } state_e;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Show-ahead byte FIFO between the UART receiver and the command FSM.
// A write while full is dropped unless a pop happens in the same cycle.
module uart_cmd_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              push;
    logic              pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (ADDR_W+1)'(DEPTH));
    assign pop      = rd_en && !empty;
    assign push     = wr_en && (!full || pop);
    assign rd_data  = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage has no reset; clearing the pointers already empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes received ASCII bytes into one-cycle stopwatch control pulses.
// Define UART_CMD_ECHO_EN to echo recognised commands to the UART transmitter.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       cmd_err,
    output logic       overflow,
    output logic       tx_start,
    output logic [7:0] tx_data
);

`ifdef UART_CMD_ECHO_EN
    localparam state_e CMD_NEXT = ECHO;
`else
    localparam state_e CMD_NEXT = IDLE;
`endif

    state_e     state_q;
    logic [7:0] cmd_reg_q;
    logic       cmd_run_q;
    logic       cmd_clear_q;
    logic       cmd_mode_q;
    logic       cmd_err_q;
    logic [7:0] fifo_head;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       unused_fifo_full;

    // Only one byte is in flight: the FSM pops only from IDLE.
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    uart_cmd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (rx_done),
        .wr_data  (rx_data),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_head),
        .full     (unused_fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

`ifdef UART_CMD_ECHO_EN
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_start       = 1'b0;
    assign tx_data        = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_reg_q   <= '0;
            cmd_run_q   <= 1'b0;
            cmd_clear_q <= 1'b0;
            cmd_mode_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
`endif
        end else begin
            cmd_run_q   <= 1'b0;
            cmd_clear_q <= 1'b0;
            cmd_mode_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            tx_start_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_reg_q <= fifo_head;
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    state_q <= IDLE;
                    case (cmd_reg_q)
                        CHAR_R_UC, CHAR_R_LC: begin
                            cmd_run_q <= 1'b1;
                            state_q   <= CMD_NEXT;
                        end
                        CHAR_C_UC, CHAR_C_LC: begin
                            cmd_clear_q <= 1'b1;
                            state_q     <= CMD_NEXT;
                        end
                        CHAR_M_UC, CHAR_M_LC: begin
                            cmd_mode_q <= 1'b1;
                            state_q    <= CMD_NEXT;
                        end
                        CHAR_CR, CHAR_LF: begin
                        end
                        default: cmd_err_q <= 1'b1;
                    endcase
                end
`ifdef UART_CMD_ECHO_EN
                ECHO: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cmd_reg_q;
                        state_q    <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_run   = cmd_run_q;
    assign cmd_clear = cmd_clear_q;
    assign cmd_mode  = cmd_mode_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: latency table, hand-written corner
// sequences and a randomized run against a byte-stream reference model.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       cmd_run;
    logic       cmd_clear;
    logic       cmd_mode;
    logic       cmd_err;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .FIFO_DEPTH (4),
        .ADDR_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .cmd_run   (cmd_run),
        .cmd_clear (cmd_clear),
        .cmd_mode  (cmd_mode),
        .cmd_err   (cmd_err),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

    // Pulse vectors are {run, clear, mode, err}.
    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_RUN   = 4'b1000;
    localparam logic [3:0] P_CLEAR = 4'b0100;
    localparam logic [3:0] P_MODE  = 4'b0010;
    localparam logic [3:0] P_ERR   = 4'b0001;

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] obs_ev_q[$];
    logic [3:0] exp_ev_q[$];
    logic [7:0] obs_tx_q[$];
    logic [7:0] exp_tx_q[$];
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pulses();
        return {cmd_run, cmd_clear, cmd_mode, cmd_err};
    endfunction

    // Reference rule: which pulse a received byte should produce.
    function automatic logic [3:0] classify(input logic [7:0] b);
        case (b)
            8'h52, 8'h72: return P_RUN;
            8'h43, 8'h63: return P_CLEAR;
            8'h4D, 8'h6D: return P_MODE;
            8'h0D, 8'h0A: return P_NONE;
            default:      return P_ERR;
        endcase
    endfunction

    function automatic bit echo_built();
`ifdef UART_CMD_ECHO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Expected effect of one accepted byte on the pulse and echo streams.
    task automatic expect_byte(input logic [7:0] b);
        logic [3:0] p;
        p = classify(b);
        if (p != P_NONE) exp_ev_q.push_back(p);
        if (echo_built() && p != P_NONE && p != P_ERR) exp_tx_q.push_back(b);
    endtask

    task automatic clear_queues();
        obs_ev_q.delete();
        exp_ev_q.delete();
        obs_tx_q.delete();
        exp_tx_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (pulses() != P_NONE) begin
                check("pulse_onehot", 32'($onehot(pulses())), 32'd1);
                obs_ev_q.push_back(pulses());
            end
            if (tx_start) obs_tx_q.push_back(tx_data);
        end
    end

    task automatic compare_streams(input string name);
        int n;
        check({name, "_pulse_count"}, obs_ev_q.size(), exp_ev_q.size());
        n = (obs_ev_q.size() < exp_ev_q.size()) ? obs_ev_q.size() : exp_ev_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_pulse[%0d]", name, i), obs_ev_q[i], exp_ev_q[i]);
        check({name, "_echo_count"}, obs_tx_q.size(), exp_tx_q.size());
        n = (obs_tx_q.size() < exp_tx_q.size()) ? obs_tx_q.size() : exp_tx_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_echo[%0d]", name, i), obs_tx_q[i], exp_tx_q[i]);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_pulses"},   pulses(), P_NONE);
        check({name, "_overflow"}, overflow, 1'b0);
        check({name, "_tx_start"}, tx_start, 1'b0);
        check({name, "_tx_data"},  tx_data,  8'h00);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rx_done = 1'b0;
        tx_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_quiet("reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[12];
        logic [7:0] seq[9];
        logic [3:0] exp_c[13];
        logic [7:0] cmds[8];
        logic [7:0] b;
        int         gap;
        int         busy_run;

        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_busy = 1'b0;

        vecs = '{
            '{8'h52, P_RUN},   '{8'h72, P_RUN},   '{8'h43, P_CLEAR},
            '{8'h63, P_CLEAR}, '{8'h4D, P_MODE},  '{8'h6D, P_MODE},
            '{8'h0D, P_NONE},  '{8'h0A, P_NONE},  '{8'h7A, P_ERR},
            '{8'h00, P_ERR},   '{8'hFF, P_ERR},   '{8'h53, P_ERR}
        };
        cmds = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h0D, 8'h0A};

        // Single-byte latency table: pulse exactly in cycle 3, echo in cycle 4.
        do_reset();
        foreach (vecs[i]) begin
            rx_data = vecs[i].data;
            rx_done = 1'b1;
            tick();
            rx_done = 1'b0;
            rx_data = 8'($urandom);
            check($sformatf("lat%0d_c1", i), pulses(), P_NONE);
            tick();
            check($sformatf("lat%0d_c2", i), pulses(), P_NONE);
            tick();
            check($sformatf("lat%0d_c3", i), pulses(), vecs[i].exp);
            tick();
            check($sformatf("lat%0d_c4", i), pulses(), P_NONE);
            if (echo_built() && vecs[i].exp != P_NONE && vecs[i].exp != P_ERR) begin
                check($sformatf("lat%0d_tx_start", i), tx_start, 1'b1);
                check($sformatf("lat%0d_tx_data", i), tx_data, vecs[i].data);
            end else begin
                check($sformatf("lat%0d_tx_start", i), tx_start, 1'b0);
            end
            repeat (3) tick();
        end

        // Back-to-back burst: clear, mode, nothing, err.
        do_reset();
        seq[0] = 8'h63; seq[1] = 8'h4D; seq[2] = 8'h0D; seq[3] = 8'h7A;
        foreach (exp_c[i]) exp_c[i] = P_NONE;
        exp_c[3] = P_CLEAR;
        if (echo_built()) begin
            exp_c[6]  = P_MODE;
            exp_c[11] = P_ERR;
        end else begin
            exp_c[5] = P_MODE;
            exp_c[9] = P_ERR;
        end
        for (int c = 0; c <= 12; c++) begin
            rx_done = (c < 4);
            rx_data = (c < 4) ? seq[c] : 8'($urandom);
            if (c >= 1) check($sformatf("b2b_c%0d", c), pulses(), exp_c[c]);
            tick();
        end
        rx_done = 1'b0;

`ifdef UART_CMD_ECHO_EN
        // Echo held off by tx_busy for 10 cycles after 0x43.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            rx_done = (c == 0);
            rx_data = 8'h43;
            tx_busy = (c >= 1 && c <= 10);
            if (c >= 1) check($sformatf("echo_busy_start_c%0d", c), tx_start, c == 12);
            if (c >= 12) check($sformatf("echo_busy_data_c%0d", c), tx_data, 8'h43);
            tick();
        end
        rx_done = 1'b0;

        // Overflow while the echo is stalled: fifth queued byte is dropped.
        do_reset();
        clear_queues();
        mon_en = 1'b1;
        seq[0] = 8'h43; seq[1] = 8'h52; seq[2] = 8'h4D;
        seq[3] = 8'h63; seq[4] = 8'h72; seq[5] = 8'h5A;
        tx_busy = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            rx_done = (c == 0) || (c >= 4 && c <= 8);
            rx_data = (c == 0) ? seq[0] : (c >= 4 && c <= 8) ? seq[c-3] : 8'($urandom);
            if (c == 8) check("ovf_before_drop", overflow, 1'b0);
            if (c == 9) check("ovf_after_drop", overflow, 1'b1);
            tick();
        end
        rx_done = 1'b0;
        tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) expect_byte(seq[i]);
`else
        // Overflow: nine writes in consecutive cycles, the ninth finds the FIFO full.
        do_reset();
        clear_queues();
        mon_en = 1'b1;
        seq = '{8'h52, 8'h43, 8'h4D, 8'h72, 8'h63, 8'h6D, 8'h52, 8'h43, 8'h5A};
        for (int c = 0; c <= 9; c++) begin
            rx_done = (c <= 8);
            rx_data = (c <= 8) ? seq[c] : 8'($urandom);
            tx_busy = 1'($urandom);
            if (c == 8) check("ovf_before_drop", overflow, 1'b0);
            if (c == 9) check("ovf_after_drop", overflow, 1'b1);
            tick();
        end
        rx_done = 1'b0;
        for (int i = 0; i < 8; i++) expect_byte(seq[i]);
`endif
        repeat (30) tick();
        mon_en = 1'b0;
        check("ovf_sticky", overflow, 1'b1);
        compare_streams("ovf");

        // Reset mid-operation with two bytes still queued.
        do_reset();
        tx_busy = 1'b1;
        seq[0] = 8'h52; seq[1] = 8'h4D; seq[2] = 8'h43;
        for (int c = 0; c <= 2; c++) begin
            rx_done = 1'b1;
            rx_data = seq[c];
            tick();
        end
        rx_done = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check_quiet("midreset");
        clear_queues();
        mon_en  = 1'b1;
        tx_busy = 1'b0;
        repeat (20) tick();
        mon_en = 1'b0;
        compare_streams("midreset");

        // Randomized byte stream against the reference model.
        do_reset();
        clear_queues();
        mon_en   = 1'b1;
        busy_run = 0;
        for (int n = 0; n < 60; n++) begin
            b   = ($urandom_range(0, 1) == 1) ? cmds[$urandom_range(0, 7)] : 8'($urandom);
            gap = $urandom_range(6, 9);
            for (int c = 0; c < gap; c++) begin
                rx_done = (c == 0);
                rx_data = (c == 0) ? b : 8'($urandom);
                if (echo_built() && busy_run >= 2) tx_busy = 1'b0;
                else tx_busy = 1'($urandom);
                busy_run = tx_busy ? busy_run + 1 : 0;
                tick();
            end
            expect_byte(b);
        end
        rx_done = 1'b0;
        tx_busy = 1'b0;
        repeat (20) tick();
        mon_en = 1'b0;
        check("rand_overflow", overflow, 1'b0);
        compare_streams("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder sitting directly downstream of the UART receiver: it consumes each received byte (`rx_data` qualified by the one-cycle `rx_done` pulse), buffers it in a small FIFO, and decodes ASCII command characters into one-cycle control pulses for the stopwatch/watch datapath. Optionally it echoes each recognised command character to the UART transmitter through a start/busy handshake.

## Interface
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, minimum 2.
- `ADDR_W`, 2: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe; byte written to FIFO on that edge.
- `tx_busy`  in  1  transmitter busy; `tx_start` must not be issued while high.
- `cmd_run`  out  1  one-cycle pulse on 'R'/'r'.
- `cmd_clear`  out  1  one-cycle pulse on 'C'/'c'.
- `cmd_mode`  out  1  one-cycle pulse on 'M'/'m'.
- `cmd_err`  out  1  one-cycle pulse on any unrecognised byte.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `tx_start`  out  1  one-cycle echo request.
- `tx_data`  out  8  echo byte; held stable from `tx_start` until next echo.

## Operation
- Reset: all outputs 0, FIFO empty, pointers 0, state IDLE, `cmd_reg` 0.
- FIFO: show-ahead; write on `rx_done`; full and no pop that cycle -> byte dropped, `overflow` set; `overflow` cleared only by reset. Simultaneous write and pop always succeed, count unchanged. Pointers wrap modulo `FIFO_DEPTH`; count is `ADDR_W+1` bits.
- FSM:
  - IDLE: if FIFO not empty -> pop, load head into `cmd_reg`, go DECODE.
  - DECODE: registers exactly one of the pulses for the next cycle from `cmd_reg`: 0x52/0x72 -> `cmd_run`; 0x43/0x63 -> `cmd_clear`; 0x4D/0x6D -> `cmd_mode`; 0x0D, 0x0A -> nothing (no error, no echo); anything else -> `cmd_err`. Recognised command with echo compiled in -> ECHO, else -> IDLE.
  - ECHO: wait while `tx_busy`=1; when 0, pulse `tx_start` one cycle with `tx_data`=`cmd_reg`, go IDLE.
- Only one byte is in flight; FIFO absorbs bursts while ECHO stalls.
- Reset mid-operation: FIFO contents discarded, any pending pulse/echo cancelled.

## Timing
- `rx_done` high in cycle 0 (FIFO empty, FSM IDLE): byte in FIFO cycle 1, FSM in DECODE cycle 2, command pulse high cycle 3. Latency 3 cycles.
- Back-to-back bytes without echo: one command every 2 cycles.
- Echo: `tx_start` earliest in cycle 4 (ECHO in cycle 3 with `tx_busy`=0 -> pulse registered, high cycle 4); each stalled cycle of `tx_busy` adds one.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `UART_CMD_ECHO_EN` defined: ECHO state present, echo as above.
- Not defined: ECHO state absent, DECODE always returns to IDLE, `tx_start` and `tx_data` constant 0, `tx_busy` ignored.

## Structure
- Package `uart_cmd_pkg`: ASCII command constants (CHAR_R/r, CHAR_C/c, CHAR_M/m, CHAR_CR, CHAR_LF) and FSM state encoding (IDLE, DECODE, ECHO).
- Sub-module `uart_cmd_fifo`: parameterised show-ahead FIFO with `wr_en`, `rd_en`, `full`, `empty`, `overflow`.

## Test plan
- Single 0x52 via `rx_done` -> `cmd_run`=1 exactly in cycle 3, all other pulses 0.
- Sequence 0x63, 0x4D, 0x0D, 0x7A back-to-back -> `cmd_clear`, `cmd_mode`, no pulse, `cmd_err`, in order, 2 cycles apart.
- Echo enabled, `tx_busy`=1 for 10 cycles after 0x43 -> `tx_start` one cycle after `tx_busy` falls, `tx_data`=0x43.
- Echo stalled, 5 bytes written with `FIFO_DEPTH`=4 -> fifth dropped, `overflow`=1 and stays 1; first four decoded in order after release.
- Reset asserted while in ECHO with 2 bytes queued -> next cycle all outputs 0, FIFO empty, no later pulses.
